// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator
// Brief    : Accumulates COUNT {cout,sum} operands from the adder stage and
//            presents the block total with a sticky wrap/overflow flag.
// Revision : 1.0  initial release
// ============================================================================
module sum_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 10,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);

    localparam int                 c_cnt_w = $clog2(COUNT + 1);
    localparam logic [c_cnt_w-1:0] c_count = c_cnt_w'(COUNT);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_cnt_w-1:0]  w_cnt_inc;
    logic                r_ovf;
    logic                w_ovf_nxt;
    logic [ACC_W:0]      w_operand;
    logic [ACC_W:0]      w_sum;

    // One extra bit on the adder exposes the carry out of the accumulator MSB.
    assign w_operand = {{(ACC_W - DATA_W){1'b0}}, in_cout, in_sum};
    assign w_sum     = {1'b0, r_acc} + w_operand;
    assign w_cnt_inc = r_cnt + c_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Handshake outputs decode only the state, so out_ready never reaches in_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (r_state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_acc_nxt = w_sum[ACC_W-1:0];
                    w_ovf_nxt = r_ovf | w_sum[ACC_W];
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_count) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_ACCUM;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase

        // Abort wins over any transfer or result handoff in the same cycle.
        if (clear) begin
            w_state_nxt = ST_ACCUM;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end
    end

    assign out_acc = r_acc;
    assign out_ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_accumulator
// Brief    : Directed self-checking bench for sum_accumulator.
// Revision : 1.0  initial release
// ============================================================================
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_sum;
    logic       in_cout;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_acc;
    logic       out_ovf;

    int checks = 0;
    int errors = 0;

    sum_accumulator #(
        .DATA_W(8),
        .ACC_W (10),
        .COUNT (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sum   (in_sum),
        .in_cout  (in_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand and steps one edge; in_valid is left high.
    task automatic put(input logic [8:0] op);
        in_valid = 1'b1;
        {in_cout, in_sum} = op;
        tick();
    endtask

    task automatic release_hold();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_cout   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_acc",   out_acc,   0);
        chk("rst_out_ovf",   out_ovf,   0);
        tick();
        tick();
        rst = 1'b0;

        // Basic block with in_valid held high
        put(9'h003);
        put(9'h005);
        put(9'h007);
        chk("basic_not_yet_valid", out_valid, 0);
        chk("basic_partial_acc",   out_acc,   10'h00F);
        put(9'h009);
        chk("basic_out_valid", out_valid, 1);
        chk("basic_in_ready",  in_ready,  0);
        chk("basic_acc",       out_acc,   10'h018);
        chk("basic_ovf",       out_ovf,   0);
        tick();
        chk("basic_hold_stable", out_acc, 10'h018);
        release_hold();
        chk("basic_rel_in_ready",  in_ready,  1);
        chk("basic_rel_out_valid", out_valid, 0);
        chk("basic_rel_acc",       out_acc,   0);

        // Wrap: 4 x 0x100 = 0x400 wraps to 0 in 10 bits
        for (int i = 0; i < 4; i++) put(9'h100);
        in_valid = 1'b0;
        chk("wrap_valid", out_valid, 1);
        chk("wrap_acc",   out_acc,   10'h000);
        chk("wrap_ovf",   out_ovf,   1);
        release_hold();
        for (int i = 0; i < 4; i++) put(9'h001);
        in_valid = 1'b0;
        chk("after_wrap_acc", out_acc, 10'h004);
        chk("after_wrap_ovf", out_ovf, 0);
        release_hold();

        // Backpressure with in_valid kept high
        for (int i = 0; i < 4; i++) put(9'h03C);
        for (int i = 0; i < 5; i++) begin
            chk("bp_acc",      out_acc,   10'h0F0);
            chk("bp_in_ready", in_ready,  0);
            chk("bp_valid",    out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_rel_in_ready", in_ready, 1);
        chk("bp_rel_acc",      out_acc,  0);

        // Bubbles: two idle cycles between operands
        put(9'h010);
        in_valid = 1'b0;
        tick();
        tick();
        chk("bub_first_acc", out_acc, 10'h010);
        put(9'h020);
        in_valid = 1'b0;
        tick();
        tick();
        put(9'h030);
        in_valid = 1'b0;
        tick();
        tick();
        chk("bub_three_acc",   out_acc,   10'h060);
        chk("bub_three_valid", out_valid, 0);
        put(9'h040);
        in_valid = 1'b0;
        chk("bub_valid", out_valid, 1);
        chk("bub_acc",   out_acc,   10'h0A0);
        release_hold();

        // Clear mid-block drops the coincident operand
        put(9'h010);
        put(9'h020);
        in_valid = 1'b0;
        chk("clr_pre_acc", out_acc, 10'h030);
        clear    = 1'b1;
        in_valid = 1'b1;
        {in_cout, in_sum} = 9'h050;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_acc",      out_acc,  0);
        chk("clr_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) put(9'h001);
        in_valid = 1'b0;
        chk("clr_block_valid", out_valid, 1);
        chk("clr_block_acc",   out_acc,   10'h004);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_hold_valid",    out_valid, 0);
        chk("clr_hold_acc",      out_acc,   0);
        chk("clr_hold_in_ready", in_ready,  1);

        // Asynchronous reset between edges, mid-block
        put(9'h005);
        put(9'h006);
        in_valid = 1'b0;
        chk("ar_mid_pre_acc", out_acc, 10'h00B);
        #2 rst = 1'b1;
        #1;
        chk("ar_mid_acc",      out_acc,  0);
        chk("ar_mid_in_ready", in_ready, 1);
        #1 rst = 1'b0;
        tick();

        // Asynchronous reset between edges, in HOLD
        for (int i = 0; i < 4; i++) put(9'h100);
        in_valid = 1'b0;
        chk("ar_hold_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_hold_valid",    out_valid, 0);
        chk("ar_hold_in_ready", in_ready,  1);
        chk("ar_hold_ovf",      out_ovf,   0);
        chk("ar_hold_acc",      out_acc,   0);
        #1 rst = 1'b0;
        tick();

        put(9'h001);
        put(9'h002);
        put(9'h003);
        put(9'h004);
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_acc",   out_acc,   10'h00A);
        chk("post_rst_ovf",   out_ovf,   0);
        release_hold();
        chk("post_rst_rel", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
